// File: rtl/isa_pkg.sv
// isa_pkg: shared opcodes, issue-FSM states and writer latencies for the 16-bit pipeline
package isa_pkg;
    localparam logic [4:0] OP_NOP  = 5'b00000;
    localparam logic [4:0] OP_HALT = 5'b00001;
    localparam int LAT_ALU = 2;
    localparam int LAT_MEM = 3;
    typedef enum logic [1:0] {RUN, STALL, DRAIN, HALTED} state_t;
endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register countdown of cycles until an in-flight write lands
// ports: rd1/rd2/dst addresses -> *_busy lookups; ld/ld_mem arm cnt[dst]; busy_mask, all_clear
module reg_scoreboard
    import isa_pkg::*;
#(
    parameter int NREG = 8,
    parameter int AW   = 3,
    parameter int CW   = 2
)(
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rd1,
    input  logic [AW-1:0]   rd2,
    input  logic [AW-1:0]   dst,
    input  logic            ld,
    input  logic            ld_mem,
    output logic            rd1_busy,
    output logic            rd2_busy,
    output logic            dst_busy,
    output logic [NREG-1:0] busy_mask,
    output logic            all_clear
);
    logic [CW-1:0] cnt [NREG];
    always_ff @(posedge clk) begin
        for (int r = 0; r < NREG; r++)
            if (rst)
                cnt[r] <= '0;
            else
                cnt[r] <= (ld && dst == AW'(r)) ? (ld_mem ? CW'(LAT_MEM) : CW'(LAT_ALU))
                        : (cnt[r] == '0) ? '0 : cnt[r] - 1'b1;
    end
    for (genvar i = 0; i < NREG; i++) begin : g_busy
        assign busy_mask[i] = cnt[i] != '0;
    end
    assign rd1_busy  = busy_mask[rd1];
    assign rd2_busy  = busy_mask[rd2];
    assign dst_busy  = busy_mask[dst];
    assign all_clear = ~|busy_mask;
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: decode-stage issue controller with hazard stalls, HALT drain and stall counter
// ports: id_* instruction fields and control bits, flush kills ID;
//        stall/issue/bubble are zero-latency decisions, halted after drain, busy_mask, stall_count
module hazard_scoreboard
    import isa_pkg::*;
#(
    parameter int NREG = 8,
    parameter int AW   = 3,
    parameter int CW   = 2
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [4:0]      id_opcode,
    input  logic [AW-1:0]   id_src1,
    input  logic [AW-1:0]   id_src2,
    input  logic [AW-1:0]   id_dst,
    input  logic            id_use_src1,
    input  logic            id_use_src2,
    input  logic            id_reg_wr,
    input  logic            id_mem_rd,
    input  logic            flush,
    output logic            stall,
    output logic            issue,
    output logic            bubble,
    output logic            halted,
    output logic [NREG-1:0] busy_mask,
    output logic [15:0]     stall_count
);
    state_t state;
    logic b1, b2, bd, all_clear, hazard, run;
    reg_scoreboard #(.NREG(NREG), .AW(AW), .CW(CW)) u_sb (
        .clk       (clk),
        .rst       (rst),
        .rd1       (id_src1),
        .rd2       (id_src2),
        .dst       (id_dst),
        .ld        (issue && id_reg_wr),
        .ld_mem    (id_mem_rd),
        .rd1_busy  (b1),
        .rd2_busy  (b2),
        .dst_busy  (bd),
        .busy_mask (busy_mask),
        .all_clear (all_clear)
    );
    // dst check catches WAW: a later ALU write could land before an earlier load
    always_comb begin
        hazard = id_valid && ((id_use_src1 && b1) || (id_use_src2 && b2) || (id_reg_wr && bd));
        run    = state == RUN || state == STALL;
        issue  = !rst && run && !flush && id_valid && !hazard;
        stall  = !rst && (run ? !flush && hazard : 1'b1);
        bubble = !issue;
        halted = !rst && state == HALTED;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            stall_count <= '0;
        end else begin
            state <= run ? ((flush || !id_valid) ? RUN : hazard ? STALL
                            : (id_opcode == OP_HALT) ? DRAIN : RUN)
                   : (state == DRAIN && all_clear) ? HALTED : state;
            if (stall && stall_count != 16'hFFFF)
                stall_count <= stall_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed stimulus with a ready-time model of the issue controller
module tb_hazard_scoreboard;
    logic       clk, rst, id_valid, id_use_src1, id_use_src2, id_reg_wr, id_mem_rd, flush;
    logic [4:0] id_opcode;
    logic [2:0] id_src1, id_src2, id_dst;
    logic       stall, issue, bubble, halted;
    logic [7:0] busy_mask;
    logic [15:0] stall_count;
    int errors = 0, checks = 0;
    localparam logic [4:0] ADD = 5'b00010, SUB = 5'b00011, LDD = 5'b00100, HALT = 5'b00001;

    hazard_scoreboard dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_src1(id_src1), .id_src2(id_src2), .id_dst(id_dst),
        .id_use_src1(id_use_src1), .id_use_src2(id_use_src2),
        .id_reg_wr(id_reg_wr), .id_mem_rd(id_mem_rd), .flush(flush),
        .stall(stall), .issue(issue), .bubble(bubble), .halted(halted),
        .busy_mask(busy_mask), .stall_count(stall_count)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: each register is free from the cycle recorded in ready[]; issue at cycle c
    // with latency L makes it busy for cycles c+1 .. c+L.
    int ready [8];
    int mode = 0, sc = 0, cyc = 0;
    bit init = 0;
    always @(negedge clk) begin
        logic [7:0] e_bm;
        logic hz, e_st, e_is, e_bu, e_ha;
        for (int r = 0; r < 8; r++) e_bm[r] = ready[r] > cyc;
        hz = id_valid && ((id_use_src1 && e_bm[id_src1]) || (id_use_src2 && e_bm[id_src2])
                          || (id_reg_wr && e_bm[id_dst]));
        if (rst)                    {e_st, e_is, e_bu, e_ha} = 4'b0010;
        else if (mode == 2)         {e_st, e_is, e_bu, e_ha} = 4'b1011;
        else if (mode == 1)         {e_st, e_is, e_bu, e_ha} = 4'b1010;
        else if (flush || !id_valid){e_st, e_is, e_bu, e_ha} = 4'b0010;
        else if (hz)                {e_st, e_is, e_bu, e_ha} = 4'b1010;
        else                        {e_st, e_is, e_bu, e_ha} = 4'b0100;
        chk("m_stall", 32'(stall), 32'(e_st));
        chk("m_issue", 32'(issue), 32'(e_is));
        chk("m_bubble", 32'(bubble), 32'(e_bu));
        chk("m_halted", 32'(halted), 32'(e_ha));
        if (!rst && init) begin
            chk("m_busy_mask", 32'(busy_mask), 32'(e_bm));
            chk("m_stall_count", 32'(stall_count), 32'(sc));
        end
        if (rst) begin
            for (int r = 0; r < 8; r++) ready[r] = 0;
            mode = 0;
            sc = 0;
            init = 1;
        end else begin
            if (e_st && sc < 65535) sc++;
            if (mode == 0 && e_is && id_opcode == HALT) mode = 1;
            else if (mode == 1 && e_bm == 8'h00) mode = 2;
            if (e_is && id_reg_wr) ready[id_dst] = cyc + 1 + (id_mem_rd ? 3 : 2);
        end
        cyc++;
    end

    task automatic set_in(input logic v, input logic [4:0] op, input logic [2:0] s1, s2, d,
                          input logic u1, u2, wr, mr, fl);
        id_valid = v; id_opcode = op; id_src1 = s1; id_src2 = s2; id_dst = d;
        id_use_src1 = u1; id_use_src2 = u2; id_reg_wr = wr; id_mem_rd = mr; flush = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        set_in(0, 5'b00000, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1;
        idle();
        tick(); tick();
        rst = 0;
        // RAW-free back-to-back issue
        set_in(1, ADD, 0, 0, 1, 0, 0, 1, 0, 0);
        chk("t1_issue_add", 32'(issue), 1);
        tick();
        chk("t1_busy_mask", 32'(busy_mask), 32'h02);
        set_in(1, SUB, 2, 4, 7, 1, 1, 1, 0, 0);
        chk("t1_issue_sub", 32'(issue), 1);
        tick(); idle(); repeat (3) tick();
        // ALU RAW: two stall cycles
        set_in(1, ADD, 0, 0, 3, 0, 0, 1, 0, 0);
        tick();
        set_in(1, ADD, 3, 0, 0, 1, 0, 0, 0, 0);
        chk("t2_stall_a", 32'(stall), 1);
        tick();
        chk("t2_stall_b", 32'(stall), 1);
        tick();
        chk("t2_issue", 32'(issue), 1);
        tick();
        chk("t2_stall_count", 32'(stall_count), 2);
        idle(); repeat (3) tick();
        // load-use RAW: three stall cycles
        set_in(1, LDD, 0, 0, 4, 0, 0, 1, 1, 0);
        tick();
        set_in(1, ADD, 4, 0, 0, 1, 0, 0, 0, 0);
        repeat (3) begin
            chk("t3_stall", 32'(stall), 1);
            chk("t3_busy4", 32'(busy_mask[4]), 1);
            tick();
        end
        chk("t3_issue", 32'(issue), 1);
        tick(); idle();
        chk("t3_stall_count", 32'(stall_count), 5);
        repeat (4) tick();
        // WAW: ALU then load to R5
        set_in(1, ADD, 0, 0, 5, 0, 0, 1, 0, 0);
        tick();
        set_in(1, LDD, 0, 0, 5, 0, 0, 1, 1, 0);
        repeat (2) begin
            chk("t4_stall", 32'(stall), 1);
            tick();
        end
        chk("t4_issue", 32'(issue), 1);
        tick(); idle();
        chk("t4_busy5_cnt3", 32'(busy_mask[5]), 1);
        repeat (2) tick();
        chk("t4_busy5_cnt1", 32'(busy_mask[5]), 1);
        tick();
        chk("t4_busy5_clear", 32'(busy_mask[5]), 0);
        repeat (2) tick();
        // flush beats hazard; scoreboard keeps counting down
        set_in(1, ADD, 0, 0, 3, 0, 0, 1, 0, 0);
        tick();
        set_in(1, ADD, 3, 0, 0, 1, 0, 0, 0, 1);
        chk("t5_stall", 32'(stall), 0);
        chk("t5_bubble", 32'(bubble), 1);
        chk("t5_issue", 32'(issue), 0);
        tick();
        chk("t5_busy3", 32'(busy_mask[3]), 1);
        set_in(1, ADD, 3, 0, 0, 1, 0, 0, 0, 0);
        chk("t5_stall_after", 32'(stall), 1);
        tick();
        chk("t5_issue_after", 32'(issue), 1);
        tick(); idle(); repeat (3) tick();
        chk("t5_stall_count", 32'(stall_count), 8);
        // HALT drain
        set_in(1, LDD, 0, 0, 6, 0, 0, 1, 1, 0);
        tick();
        set_in(1, HALT, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t6_halt_issue", 32'(issue), 1);
        tick();
        set_in(1, ADD, 0, 0, 6, 0, 0, 1, 0, 1);
        chk("t6_drain_stall", 32'(stall), 1);
        chk("t6_not_halted", 32'(halted), 0);
        repeat (3) tick();
        chk("t6_halted", 32'(halted), 1);
        chk("t6_stall_count", 32'(stall_count), 11);
        repeat (3) tick();
        chk("t6_halted_hold", 32'(halted), 1);
        chk("t6_no_issue", 32'(issue), 0);
        repeat (65540) @(posedge clk);
        #1;
        chk("sat_stall_count", 32'(stall_count), 32'hFFFF);
        rst = 1;
        #1;
        chk("rst_halted", 32'(halted), 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_bubble", 32'(bubble), 1);
        tick();
        rst = 0;
        idle();
        chk("rst_stall_count", 32'(stall_count), 0);
        chk("rst_busy_mask", 32'(busy_mask), 0);
        set_in(1, ADD, 0, 0, 1, 0, 0, 1, 0, 0);
        chk("rst_issue", 32'(issue), 1);
        tick(); idle(); tick(); tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
